// File: rtl/dmem_access_unit.sv
// Load/store initiator between the CPU memory stage and a synchronous word memory.
// Handles byte/half/word accesses with lane extraction, extension and read-modify-write.
module dmem_access_unit #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data
);

  // state     | meaning
  // S_IDLE    | waiting for a request, req_ready high
  // S_READ    | read strobe for a load or sub-word store
  // S_CAPTURE | memory data valid, extract or merge lane
  // S_WRITE   | write strobe with final word
  // S_RESP    | response held until resp_ready
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [1:0]  SZ_BAD    = 2'b11;
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

  state_t      state, state_next;
  logic        accept;
  logic        req_bad;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Errors are decided from the live request so no strobe is ever issued for them
  always_comb begin
    req_bad = 1'b0;
    if (req_size == SZ_BAD)                               req_bad = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])               req_bad = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    req_bad = 1'b1;
    if (req_addr[31:2] >= DEPTH_IDX)                      req_bad = 1'b1;
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          if (req_bad)                                state_next = S_RESP;
          else if (!req_we)                           state_next = S_READ;
          else if (req_size == SZ_WORD)               state_next = S_WRITE;
          else                                        state_next = S_READ;
        end
      end
      S_READ: begin
        mem_rd_en  = 1'b1;
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_next = lat_we ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_wr_en  = 1'b1;
        state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Little-endian lane selection of the word returned by memory
  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (lat_off)
      2'd0: byte_lane = mem_rdata[7:0];
      2'd1: byte_lane = mem_rdata[15:8];
      2'd2: byte_lane = mem_rdata[23:16];
      2'd3: byte_lane = mem_rdata[31:24];
      default: byte_lane = mem_rdata[7:0];
    endcase
    half_lane = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    case (lat_size)
      SZ_BYTE: load_data = {{24{lat_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{lat_signed & half_lane[15]}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    merge_data = mem_rdata;
    if (lat_size == SZ_BYTE) begin
      case (lat_off)
        2'd0: merge_data[7:0]   = lat_wdata[7:0];
        2'd1: merge_data[15:8]  = lat_wdata[7:0];
        2'd2: merge_data[23:16] = lat_wdata[7:0];
        2'd3: merge_data[31:24] = lat_wdata[7:0];
        default: merge_data = mem_rdata;
      endcase
    end else if (lat_size == SZ_HALF) begin
      if (lat_off[1]) merge_data[31:16] = lat_wdata[15:0];
      else            merge_data[15:0]  = lat_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we      <= 1'b0;
      lat_size    <= 2'b00;
      lat_signed  <= 1'b0;
      lat_off     <= 2'b00;
      lat_wdata   <= '0;
      mem_addr    <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      if (accept) begin
        lat_we     <= req_we;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_off    <= req_addr[1:0];
        lat_wdata  <= req_wdata;
        mem_addr   <= {2'b00, req_addr[31:2]};
        resp_rdata <= '0;
        resp_err   <= req_bad;
        // Word stores skip the read, so their data goes straight to the write port
        mem_wr_data <= (req_we && req_size == SZ_WORD && !req_bad) ? req_wdata : '0;
      end
      if (state == S_CAPTURE) begin
        if (lat_we) mem_wr_data <= merge_data;
        else        resp_rdata  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, hand sequences for backpressure and
// mid-write reset, and random requests checked against an arithmetic memory model.
module tb_dmem_access_unit;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_wr_data;
  logic        mem_rd_en, mem_wr_en;

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory responder, not reset
  logic [31:0] mem_arr [DEPTH] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_addr[4:0]] <= mem_wr_data;
    if (mem_rd_en) mem_rdata <= mem_arr[mem_addr[4:0]];
  end

  int          rd_cnt = 0, wr_cnt = 0, overlap = 0;
  logic [31:0] wr_word = '0, wr_idx = '0;
  always @(posedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      wr_word = mem_wr_data;
      wr_idx  = mem_addr;
    end
    if (mem_rd_en && mem_wr_en) overlap++;
  end

  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outcome of one request derived from the access rules with plain arithmetic
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output int lat,
                                output int nrd, output int nwr, output logic [31:0] wword);
    int unsigned nbytes, idx, off;
    longint unsigned mask, v, word;
    nbytes = 1 << size;
    idx    = addr / 4;
    off    = addr % 4;
    err    = (size == 2'b11) || (addr % nbytes != 0) || (idx >= DEPTH);
    rdata = '0; wword = '0; lat = 1; nrd = 0; nwr = 0;
    if (!err) begin
      mask = (64'd1 << (8 * nbytes)) - 1;
      word = ref_mem[idx];
      if (!we) begin
        v = (word >> (8 * off)) & mask;
        if (sgn && nbytes < 4 && v >= (mask + 1) / 2) v = v | (64'hFFFF_FFFF & ~mask);
        rdata = v[31:0];
        lat = 3; nrd = 1;
      end else begin
        v = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        wword = v[31:0];
        nwr = 1;
        lat = (nbytes == 4) ? 2 : 4;
        nrd = (nbytes == 4) ? 0 : 1;
      end
    end
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    logic [31:0] m_rdata, m_wword, held;
    logic        m_err;
    int          m_lat, m_rd, m_wr, lat, rd0, wr0, w;
    model(we, size, sgn, addr, wdata, m_rdata, m_err, m_lat, m_rd, m_wr, m_wword);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, m_lat);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    held = resp_rdata;
    // Stray request while busy must be ignored
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, held);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("post_hs_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_hs_ready", {31'b0, req_ready}, 32'd1);
    chk("rd_pulses", rd_cnt - rd0, m_rd);
    chk("wr_pulses", wr_cnt - wr0, m_wr);
    if (m_wr == 1) begin
      chk("wr_word", wr_word, m_wword);
      chk("wr_idx", wr_idx, addr >> 2);
      ref_mem[addr >> 2] = m_wword;
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  vec_t tbl [19];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    chk({tag, "_mem_wr_en"}, {31'b0, mem_wr_en}, 32'd0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
  endtask

  initial begin
    logic [31:0] r_rdata, r_wword, r_addr;
    logic        r_err, r_we, r_sgn;
    logic [1:0]  r_size;
    int          r_lat, r_rd, r_wr;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'hFFFFFFBE, 1'b0, 0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        32'h000000BE, 1'b0, 0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0, 0};
    tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'h0000DEAD, 1'b0, 0};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h0B, 32'h11,       32'h0,        1'b0, 0};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h11ADBEEF, 1'b0, 5};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1, 0};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF,     32'h0,        1'b1, 0};
    tbl[10] = '{1'b1, 2'b11, 1'b0, 32'h08, 32'h0,        32'h0,        1'b1, 0};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 0};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h11ADBEEF, 1'b0, 0};
    tbl[13] = '{1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D, 32'h0,        1'b0, 0};
    tbl[14] = '{1'b0, 2'b01, 1'b1, 32'h7E, 32'h0,        32'hFFFFCAFE, 1'b0, 0};
    tbl[15] = '{1'b1, 2'b01, 1'b0, 32'h7E, 32'h1234,     32'h0,        1'b0, 0};
    tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        32'h1234F00D, 1'b0, 2};
    tbl[17] = '{1'b1, 2'b10, 1'b0, 32'h04, 32'hA5A55A5A, 32'h0,        1'b0, 0};
    tbl[18] = '{1'b0, 2'b00, 1'b0, 32'h07, 32'h0,        32'h000000A5, 1'b0, 0};

    #12;
    check_reset_outputs("rst");
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

    foreach (tbl[i])
      run_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].hold);

    // Reset while the write strobe of a word store is active
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h04; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_wr_en_before", {31'b0, mem_wr_en}, 32'd1);
    chk("mid_wr_addr", mem_addr, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'b0, req_ready}, 32'd1);
    run_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hA5A55A5A, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_sgn  = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 159));
      model(r_we, r_size, r_sgn, r_addr, 32'($urandom), r_rdata, r_err, r_lat, r_rd, r_wr, r_wword);
      run_req(r_we, r_size, r_sgn, r_addr, $urandom, r_rdata, r_err, $urandom_range(0, 3));
    end

    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem_arr[i], ref_mem[i]);
    chk("rd_wr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
